// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: pipeline-register enables/flushes, halt FSM and stall counter.
// Optional build macro PIPELINE_CTRL_FORWARD_EN: when defined, only load-use hazards stall (forwarding resolves RAW).
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        ex_dREN,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_usesrt,
  input  logic        ex_RegWEN,
  input  logic        mem_RegWEN,
  input  logic [4:0]  ex_wsel,
  input  logic [4:0]  mem_wsel,
  input  logic        ex_taken,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        halt,
  output logic [31:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] stall_cnt_reg, stall_cnt_next;
  logic        data_stall, load_use, raw_hazard;

  // Register 0 is hardwired, so a write to or read of it never creates a hazard.
  function automatic logic src_match(input logic [4:0] wreg, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic usesrt);
    return (wreg != 5'd0) && ((wreg == rs) || (usesrt && (wreg == rt)));
  endfunction

  assign data_stall = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use   = ex_dREN & src_match(ex_rt, id_rs, id_rt, id_usesrt);

`ifdef PIPELINE_CTRL_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_RegWEN, mem_RegWEN, ex_wsel, mem_wsel};
  assign raw_hazard = 1'b0;
`else
  assign raw_hazard = (ex_RegWEN  & src_match(ex_wsel,  id_rs, id_rt, id_usesrt))
                    | (mem_RegWEN & src_match(mem_wsel, id_rs, id_rt, id_usesrt));
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= RUN;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    stall_cnt_next = stall_cnt_reg;
    if (state_reg == RUN) begin
      if (wb_halt)
        state_next = HALTED;
      if (!pc_en && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_next = stall_cnt_reg + 32'd1;
    end
  end

  // Stall sources are evaluated in strict priority; the first match wins.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    memwb_flush = 1'b0;
    case (state_reg)
      HALTED: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      default: begin
        if (data_stall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end else if (ex_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use || raw_hazard) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
    endcase
  end

  assign halt      = (state_reg == HALTED);
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected control vectors are queued at drive time and compared once outputs settle.
module tb_pipeline_ctrl;

  logic        CLK, nRST;
  logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, id_usesrt;
  logic        ex_RegWEN, mem_RegWEN, ex_taken, wb_halt;
  logic [4:0]  ex_rt, id_rs, id_rt, ex_wsel, mem_wsel;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [31:0] stall_cnt;
  logic [8:0]  ctrl_obs;

  // Vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush
  localparam logic [8:0] P_RUN    = 9'b110101010;
  localparam logic [8:0] P_DSTALL = 9'b000000011;
  localparam logic [8:0] P_TAKEN  = 9'b111111010;
  localparam logic [8:0] P_LU     = 9'b000111010;
  localparam logic [8:0] P_FMISS  = 9'b011101010;

  int          tests_run, tests_failed;
  logic [8:0]  exp_q[$];
  logic [31:0] exp_cnt;
  logic        exp_halt;

  pipeline_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_usesrt(id_usesrt),
    .ex_RegWEN(ex_RegWEN), .mem_RegWEN(mem_RegWEN), .ex_wsel(ex_wsel), .mem_wsel(mem_wsel),
    .ex_taken(ex_taken), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush), .halt(halt), .stall_cnt(stall_cnt)
  );

  assign ctrl_obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, exmem_flush, memwb_en, memwb_flush};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic src_hit(input logic [4:0] w);
    return (w != 5'd0) && ((w == id_rs) || (id_usesrt && (w == id_rt)));
  endfunction

  function automatic logic [8:0] ref_ctrl();
    logic raw;
    if (exp_halt) return 9'b0;
    if ((mem_dREN || mem_dWEN) && !dhit) return P_DSTALL;
    if (ex_taken) return P_TAKEN;
    raw = 1'b0;
`ifndef PIPELINE_CTRL_FORWARD_EN
    raw = (ex_RegWEN && src_hit(ex_wsel)) || (mem_RegWEN && src_hit(mem_wsel));
`endif
    if ((ex_dREN && src_hit(ex_rt)) || raw) return P_LU;
    if (!ihit) return P_FMISS;
    return P_RUN;
  endfunction

  task automatic set_idle();
    ihit = 1; dhit = 1; mem_dREN = 0; mem_dWEN = 0; ex_dREN = 0; ex_rt = 0;
    id_rs = 0; id_rt = 0; id_usesrt = 0; ex_RegWEN = 0; mem_RegWEN = 0;
    ex_wsel = 0; mem_wsel = 0; ex_taken = 0; wb_halt = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    logic [8:0] e;
    exp_q.push_back(ref_ctrl());
    #1;
    e = exp_q.pop_front();
    check({tag, ".ctrl"}, 32'(ctrl_obs), 32'(e));
    if (!exp_halt) begin
      if (!e[8] && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      if (wb_halt) exp_halt = 1'b1;
    end
    @(posedge CLK);
    #1;
    check({tag, ".halt"}, 32'(halt), 32'(exp_halt));
    check({tag, ".cnt"}, stall_cnt, exp_cnt);
    $display("[TB] %s ctrl=%b halt=%0d stall_cnt=%0h", tag, e, halt, stall_cnt);
    @(negedge CLK);
  endtask

  task automatic reset_now(input string tag);
    nRST = 1'b0;
    #1;
    exp_cnt = 0;
    exp_halt = 1'b0;
    check({tag, ".halt"}, 32'(halt), 32'd0);
    check({tag, ".cnt"}, stall_cnt, 32'd0);
    exp_q.push_back(ref_ctrl());
    check({tag, ".ctrl"}, 32'(ctrl_obs), 32'(exp_q.pop_front()));
    $display("[TB] %s reset halt=%0d stall_cnt=%0h", tag, halt, stall_cnt);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; exp_cnt = 0; exp_halt = 0;
    set_idle();
    nRST = 1'b1;
    #2;
    reset_now("rst");
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);

    step("idle");
    mem_dREN = 1; dhit = 0;
    for (int i = 0; i < 3; i++) step($sformatf("dstall%0d", i));
    check("dstall.cnt3", stall_cnt, 32'd3);
    dhit = 1; step("dhit_done");
    mem_dREN = 0; mem_dWEN = 1; dhit = 0; step("store_stall");
    set_idle();

    ex_dREN = 1; ex_rt = 5; id_rs = 5; step("lu_rs");
    ex_rt = 0; id_rs = 0; step("lu_r0");
    ex_rt = 7; id_rt = 7; id_usesrt = 1; step("lu_rt");
    id_usesrt = 0; step("lu_rt_unused");
    ex_rt = 5; id_rs = 5; ex_taken = 1; ihit = 0; step("taken_lu");
    mem_dREN = 1; dhit = 0; step("dstall_over_taken");
    set_idle();
    ihit = 0; step("fetch_miss");
    set_idle();

    ex_RegWEN = 1; ex_wsel = 8; id_rt = 8; id_usesrt = 1; step("raw_ex");
    set_idle();
    mem_RegWEN = 1; mem_wsel = 3; id_rs = 3; step("raw_mem");
    mem_wsel = 0; id_rs = 0; step("raw_r0");
    set_idle();

    for (int i = 0; i < 40; i++) begin
      ihit = 1'($urandom_range(0, 3) != 0); dhit = 1'($urandom_range(0, 3) != 0);
      mem_dREN = 1'($urandom); mem_dWEN = 1'($urandom_range(0, 3) == 0);
      ex_dREN = 1'($urandom); ex_rt = 5'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_usesrt = 1'($urandom); ex_RegWEN = 1'($urandom); mem_RegWEN = 1'($urandom);
      ex_wsel = 5'($urandom_range(0, 3)); mem_wsel = 5'($urandom_range(0, 3));
      ex_taken = 1'($urandom_range(0, 3) == 0);
      step($sformatf("rand%0d", i));
    end
    set_idle();

    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    @(posedge CLK);
    #1;
    release dut.stall_cnt_reg;
    exp_cnt = 32'hFFFF_FFFE;
    check("preset.cnt", stall_cnt, exp_cnt);
    @(negedge CLK);
    mem_dREN = 1; dhit = 0;
    for (int i = 0; i < 3; i++) step($sformatf("sat%0d", i));
    check("sat.cnt", stall_cnt, 32'hFFFF_FFFF);
    reset_now("rst_mid_stall");
    @(negedge CLK); nRST = 1'b1;
    step("stall_after_rst");

    wb_halt = 1; step("halt_req");
    for (int i = 0; i < 10; i++) begin
      wb_halt = 1'($urandom); ihit = 1'($urandom); dhit = 1'($urandom);
      ex_taken = 1'($urandom); ex_dREN = 1'($urandom);
      step($sformatf("halted%0d", i));
    end
    set_idle();
    reset_now("rst_halted");
    @(negedge CLK); nRST = 1'b1;
    step("run_after_halt");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  clock; all state updates on posedge CLK.
REQ-002 SHALL have ports: nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: ihit  in  1  instruction fetch complete this cycle.
REQ-004 SHALL have ports: dhit  in  1  data access complete this cycle.
REQ-005 SHALL have ports: mem_dREN, mem_dWEN  in  1 each  load/store currently in MEM stage.
REQ-006 SHALL have ports: ex_dREN  in  1  load currently in EX stage; ex_rt  in  5  its destination register.
REQ-007 SHALL have ports: id_rs, id_rt  in  5 each  source registers of instruction in ID; id_usesrt  in  1  ID instruction reads rt.
REQ-008 SHALL have ports: ex_RegWEN, mem_RegWEN  in  1 each; ex_wsel, mem_wsel  in  5 each  pending writes in EX/MEM.
REQ-009 SHALL have ports: ex_taken  in  1  branch/jump resolved taken in EX; wb_halt  in  1  halt instruction in WB.
REQ-010 SHALL have ports: pc_en  out  1; ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush  out  1 each  pipeline-register controls (flush acts only with en=1).
REQ-011 SHALL have ports: halt  out  1  processor halted; stall_cnt  out  32  stall-cycle counter.

Function
REQ-012 SHALL implement FSM states RUN and HALTED; RUN->HALTED on posedge when wb_halt=1 in RUN; HALTED sticky until nRST.
REQ-013 SHALL in HALTED drive all en and flush outputs 0 and halt=1 (registered, asserted the cycle after wb_halt sampled).
REQ-014 SHALL in RUN default all en=1, all flush=0, pc_en=1, modified by REQ-015..018 in strict priority order (first match wins).
REQ-015 SHALL on data stall (mem_dREN|mem_dWEN)&~dhit: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1, memwb_flush=1.
REQ-016 SHALL on ex_taken=1: pc_en=1, ifid_flush=1, idex_flush=1 (both younger instructions squashed); overrides load-use and fetch miss.
REQ-017 SHALL on load-use: ex_dREN=1, ex_rt!=0, and (ex_rt==id_rs or (id_usesrt and ex_rt==id_rt)): pc_en=0, ifid_en=0, idex_flush=1.
REQ-018 SHALL on fetch miss ihit=0: pc_en=0, ifid_flush=1; downstream stages advance.
REQ-019 SHALL compute all en/flush outputs combinationally from inputs and current state (zero-cycle latency).
REQ-020 SHALL increment stall_cnt on each RUN-state posedge where pc_en=0; saturate at 32'hFFFFFFFF; hold in HALTED.
REQ-021 SHALL treat register 0 as never hazardous in every comparison.
REQ-022 SHALL give wb_halt precedence over any stall in the same cycle: transition to HALTED regardless of dhit/ihit.

Reset
REQ-023 SHALL on nRST=0, asynchronously: state=RUN, halt=0, stall_cnt=0; combinational outputs then follow RUN rules.
REQ-024 SHALL abandon any stall in progress on reset mid-operation; no stall state is retained.

Configuration
REQ-025 SHALL use macro PIPELINE_CTRL_FORWARD_EN: defined -> RAW hazards resolved by forwarding; only load-use stalls per REQ-017.
REQ-026 SHALL with PIPELINE_CTRL_FORWARD_EN undefined additionally treat as load-use-class stall (same outputs and priority as REQ-017) any ID source match with ex_wsel when ex_RegWEN=1, or mem_wsel when mem_RegWEN=1, wsel!=0.

Verification
REQ-027 SHALL cover: mem_dREN=1, dhit=0 for 3 cycles -> pc_en/ifid_en/idex_en/exmem_en=0, memwb_flush=1 each cycle; stall_cnt=3.
REQ-028 SHALL cover: ex_dREN=1, ex_rt=5, id_rs=5 -> pc_en=0, ifid_en=0, idex_flush=1 for that cycle; ex_rt=0, id_rs=0 -> no stall.
REQ-029 SHALL cover: ex_taken=1 with simultaneous load-use match -> pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=1.
REQ-030 SHALL cover: wb_halt=1 with dhit=0 pending -> next cycle halt=1, all en=0; persists 10 cycles until nRST.
REQ-031 SHALL cover: FORWARD_EN undefined, ex_RegWEN=1, ex_wsel=8, id_rt=8, id_usesrt=1 -> stall; defined -> no stall.
REQ-032 SHALL cover: stall_cnt preset to 32'hFFFFFFFE, 3 stall cycles -> stall_cnt=32'hFFFFFFFF; nRST mid-stall -> stall_cnt=0, halt=0.
